// File: rtl/accum_counter_pkg.sv
// accum_counter_pkg
//   Shared definitions for the accumulating counter.
//   - MODE_W : width of the operation select
//   - mode_e : operation applied on an enabled cycle
package accum_counter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/accum_counter_alu.sv
// accum_counter_alu
//   Purely combinational next-state unit for accum_counter.
//   The step is expected to be already clamped to MAX_VAL, so at most
//   one wrap correction is ever needed.
//   Ports:
//     i_count  in  WIDTH   current count
//     i_step   in  WIDTH   clamped step / load value
//     i_mode   in  MODE_W  operation (mode_e encoding)
//     o_next   out WIDTH   next count
//     o_ovf    out 1       ADD crossed the ceiling
//     o_unf    out 1       SUB went below zero
module accum_counter_alu
    import accum_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0]  i_count,
    input  logic [WIDTH-1:0]  i_step,
    input  logic [MODE_W-1:0] i_mode,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    // MAX_VAL+1 reduced modulo 2**WIDTH; it is 0 for a full-range ceiling,
    // which makes the wrap arithmetic below the plain modular result.
    localparam logic [WIDTH-1:0] RANGE_W = WIDTH'(MAX_VAL + 1);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_add_wrap;
    logic [WIDTH-1:0] w_sub_wrap;

    // The true wrapped results always lie in 0..MAX_VAL, so computing them
    // modulo 2**WIDTH loses nothing.
    assign w_sum      = {1'b0, i_count} + {1'b0, i_step};
    assign w_add_wrap = i_count + i_step - RANGE_W;
    assign w_sub_wrap = i_count + RANGE_W - i_step;

    always_comb begin
        o_next = i_count;
        o_ovf  = 1'b0;
        o_unf  = 1'b0;
        case (mode_e'(i_mode))
            MODE_ADD: begin
                if (w_sum > MAX_EXT) begin
                    o_ovf  = 1'b1;
                    o_next = (SATURATE != 0) ? MAX_W : w_add_wrap;
                end else begin
                    o_next = w_sum[WIDTH-1:0];
                end
            end
            MODE_SUB: begin
                if (i_step > i_count) begin
                    o_unf  = 1'b1;
                    o_next = (SATURATE != 0) ? '0 : w_sub_wrap;
                end else begin
                    o_next = i_count - i_step;
                end
            end
            MODE_LOAD: begin
                o_next = i_step;
            end
            default: begin
                o_next = i_count;
            end
        endcase
    end

endmodule

// File: rtl/accum_counter.sv
// accum_counter
//   WIDTH-bit accumulating counter bounded by MAX_VAL that adds, subtracts
//   or loads a step each enabled cycle, wrapping or saturating at the
//   bounds, with overflow/underflow pulses and sticky flags.
//   There is no handshake: an operation is accepted on every rising edge
//   and its result is visible on the outputs right after that edge.
//   Ports:
//     clk         in  1      rising-edge clock
//     reset_n     in  1      asynchronous active-low reset
//     clear       in  1      synchronous clear of count and sticky flags
//     enable      in  1      qualifies mode; low means hold
//     mode        in  2      00 HOLD, 01 ADD, 10 SUB, 11 LOAD
//     count_in    in  WIDTH  step or load value
//     count_out   out WIDTH  registered count
//     ovf_pulse   out 1      one-cycle overflow pulse
//     unf_pulse   out 1      one-cycle underflow pulse
//     ovf_sticky  out 1      overflow seen since last clear/reset
//     unf_sticky  out 1      underflow seen since last clear/reset
//     at_max      out 1      count_out == MAX_VAL
//     at_zero     out 1      count_out == 0
module accum_counter
    import accum_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count_out,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0]  r_count;
    logic              r_ovf_pulse;
    logic              r_unf_pulse;
    logic              r_ovf_sticky;
    logic              r_unf_sticky;

    logic [WIDTH-1:0]  w_step;
    logic [MODE_W-1:0] w_mode;
    logic [WIDTH-1:0]  w_next;
    logic              w_ovf;
    logic              w_unf;

    // Step is clamped to the ceiling before any mode uses it.
    assign w_step = (count_in > MAX_W) ? MAX_W : count_in;
    // A disabled cycle is presented to the ALU as HOLD, so it can never
    // produce an event.
    assign w_mode = enable ? mode : MODE_HOLD;

    accum_counter_alu #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_alu (
        .i_count (r_count),
        .i_step  (w_step),
        .i_mode  (w_mode),
        .o_next  (w_next),
        .o_ovf   (w_ovf),
        .o_unf   (w_unf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_ovf_pulse  <= 1'b0;
            r_unf_pulse  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else if (clear) begin
            // Clear outranks any event in the same cycle.
            r_count      <= '0;
            r_ovf_pulse  <= 1'b0;
            r_unf_pulse  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            r_count      <= w_next;
            r_ovf_pulse  <= w_ovf;
            r_unf_pulse  <= w_unf;
            r_ovf_sticky <= r_ovf_sticky | w_ovf;
            r_unf_sticky <= r_unf_sticky | w_unf;
        end
    end

    assign count_out  = r_count;
    assign ovf_pulse  = r_ovf_pulse;
    assign unf_pulse  = r_unf_pulse;
    assign ovf_sticky = r_ovf_sticky;
    assign unf_sticky = r_unf_sticky;
    assign at_max     = (r_count == MAX_W);
    assign at_zero    = (r_count == '0);

endmodule
